// File: rtl/bp_pkg.sv
// bp_pkg: shared encodings and types for the branch predictor controller
package bp_pkg;
  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_TRAIN = 2'b01;
  localparam logic [1:0] OP_INIT  = 2'b10;
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  typedef struct packed {
    logic [31:0] pc;
    logic        pred;
  } entry_t;
endpackage

// File: rtl/bp_inflight_fifo.sv
// bp_inflight_fifo: in-order queue of predicted branches awaiting resolution
module bp_inflight_fifo import bp_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  logic   clear,
  input  entry_t din,
  output logic   full,
  output logic   empty,
  output entry_t head
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd_ptr];
  // pointers and occupancy; clear drops every entry at once
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  // entry storage, no reset needed since occupancy gates validity
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/bp_ctrl.sv
// bp_ctrl: init sweep, in-flight tracking and training of the 2-bit predictor table
module bp_ctrl import bp_pkg::*; #(
  parameter int         DEPTH    = 4,
  parameter int         IDX_W    = 8,
  parameter logic [1:0] INIT_VAL = 2'b01
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_valid,
  input  logic [31:0]      fetch_pc,
  input  logic             fetch_pred,
  input  logic             ex_valid,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             stall_fetch,
  output logic             flush,
  output logic [31:0]      redirect_pc,
  output logic [1:0]       tbl_op,
  output logic [IDX_W-1:0] tbl_index,
  output logic             tbl_taken,
  output logic [1:0]       tbl_wdata,
  output logic             err_underflow,
  output logic [31:0]      br_count,
  output logic [31:0]      mispred_count
);
  state_t state, state_nxt;
  logic [IDX_W-1:0] init_idx;
  logic full, empty, in_run, resolve, mispred, push;
  entry_t din, head;
  assign in_run      = state == ST_RUN;
  assign resolve     = in_run & ex_valid & ~empty;
  assign mispred     = resolve & (head.pred != ex_taken);
  assign push        = in_run & fetch_valid & ~full & ~mispred & ~flush;
  assign stall_fetch = ~in_run | full;
  assign din         = '{pc: fetch_pc, pred: fetch_pred};
  bp_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (resolve),
    .clear (mispred),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ST_INIT;
    else state <= state_nxt;
  // leave the sweep once the last table entry has been written
  always_comb begin
    state_nxt = state;
    if (state == ST_INIT && &init_idx) state_nxt = ST_RUN;
  end
  // registered table commands, flush/redirect and statistics
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      init_idx      <= '0;
      flush         <= 1'b0;
      redirect_pc   <= '0;
      tbl_op        <= OP_NONE;
      tbl_index     <= '0;
      tbl_taken     <= 1'b0;
      tbl_wdata     <= '0;
      err_underflow <= 1'b0;
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      tbl_op <= OP_NONE;
      flush  <= 1'b0;
      if (state == ST_INIT) begin
        tbl_op    <= OP_INIT;
        tbl_index <= init_idx;
        tbl_wdata <= INIT_VAL;
        init_idx  <= init_idx + 1'b1;
      end
      if (resolve) begin
        tbl_op    <= OP_TRAIN;
        tbl_index <= head.pc[IDX_W+1:2];
        tbl_taken <= ex_taken;
        br_count  <= br_count + 32'd1;
      end
      if (mispred) begin
        flush         <= 1'b1;
        redirect_pc   <= ex_taken ? ex_target : head.pc + 32'd4;
        mispred_count <= mispred_count + 32'd1;
      end
      if (in_run & ex_valid & empty) err_underflow <= 1'b1;
    end
endmodule

// File: tb/tb_bp_ctrl.sv
// tb_bp_ctrl: scoreboard bench for bp_ctrl against a queue-based reference model
module tb_bp_ctrl;
  localparam int DEPTH = 4;
  logic clk = 0;
  logic reset = 0;
  logic fetch_valid = 0, fetch_pred = 0, ex_valid = 0, ex_taken = 0;
  logic [31:0] fetch_pc = 0, ex_target = 0;
  logic stall_fetch, flush, tbl_taken, err_underflow;
  logic [31:0] redirect_pc, br_count, mispred_count;
  logic [1:0] tbl_op, tbl_wdata;
  logic [7:0] tbl_index;
  bp_ctrl #(.DEPTH(DEPTH), .IDX_W(8), .INIT_VAL(2'b01)) dut (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
    .fetch_pred(fetch_pred), .ex_valid(ex_valid), .ex_taken(ex_taken),
    .ex_target(ex_target), .stall_fetch(stall_fetch), .flush(flush),
    .redirect_pc(redirect_pc), .tbl_op(tbl_op), .tbl_index(tbl_index),
    .tbl_taken(tbl_taken), .tbl_wdata(tbl_wdata), .err_underflow(err_underflow),
    .br_count(br_count), .mispred_count(mispred_count)
  );
  always #5 clk = ~clk;
  typedef struct { logic [31:0] pc; bit pred; } ent_t;
  typedef struct { logic [7:0] idx; bit taken; bit fl; logic [31:0] rpc; int br; int mis; } exp_t;
  ent_t mq[$];
  exp_t expq[$];
  int n_checks = 0, n_pass = 0;
  int br_m, mis_m;
  logic [31:0] rpc_m;
  bit err_m, flush_prev, mon_on = 0;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction
  task automatic model_reset();
    mq.delete();
    expq.delete();
    br_m = 0; mis_m = 0; rpc_m = 0; err_m = 0; flush_prev = 0;
  endtask
  task automatic check_reset();
    chk("rst_flush", flush, 0);
    chk("rst_redirect", redirect_pc, 0);
    chk("rst_op", tbl_op, 0);
    chk("rst_index", tbl_index, 0);
    chk("rst_taken", tbl_taken, 0);
    chk("rst_wdata", tbl_wdata, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_br", br_count, 0);
    chk("rst_mis", mispred_count, 0);
    chk("rst_stall", stall_fetch, 1);
  endtask
  task automatic sweep(int upto);
    for (int k = 0; k < upto; k++) begin
      @(negedge clk);
      chk("init_op", tbl_op, 2'b10);
      chk("init_index", tbl_index, k[7:0]);
      chk("init_wdata", tbl_wdata, 2'b01);
      chk("init_stall", stall_fetch, (k == 255) ? 0 : 1);
    end
  endtask
  task automatic cycle(bit fv, logic [31:0] pc, bit pred, bit ev, bit tk, logic [31:0] tgt);
    bit full, res, mis;
    exp_t e;
    full = mq.size() == DEPTH;
    chk("stall", stall_fetch, full);
    chk("err_underflow", err_underflow, err_m);
    fetch_valid = fv; fetch_pc = pc; fetch_pred = pred;
    ex_valid = ev; ex_taken = tk; ex_target = tgt;
    res = ev && mq.size() > 0;
    mis = res && (mq[0].pred != tk);
    if (ev && !res) err_m = 1;
    if (res) begin
      br_m++;
      if (mis) begin
        mis_m++;
        rpc_m = tk ? tgt : mq[0].pc + 32'd4;
      end
      e.idx = mq[0].pc[9:2]; e.taken = tk; e.fl = mis; e.rpc = rpc_m; e.br = br_m; e.mis = mis_m;
      expq.push_back(e);
      void'(mq.pop_front());
    end
    if (mis) mq.delete();
    else if (fv && !full && !flush_prev) mq.push_back('{pc, pred});
    flush_prev = mis;
    @(posedge clk);
    #1;
    fetch_valid = 0; ex_valid = 0;
  endtask
  // monitor: every train command must match the oldest expected resolution
  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_on) begin
      if (tbl_op == 2'b01) begin
        if (expq.size() == 0) chk("train_unexpected", tbl_op, 2'b00);
        else begin
          e = expq.pop_front();
          chk("train_index", tbl_index, e.idx);
          chk("train_taken", tbl_taken, e.taken);
          chk("train_flush", flush, e.fl);
          chk("redirect_pc", redirect_pc, e.rpc);
          chk("br_count", br_count, e.br);
          chk("mispred_count", mispred_count, e.mis);
        end
      end else begin
        chk("idle_op", tbl_op, 2'b00);
        chk("idle_flush", flush, 0);
      end
    end
  end
  task automatic restart();
    @(negedge clk);
    reset = 0;
    sweep(256);
    @(negedge clk);
    chk("post_init_op", tbl_op, 2'b00);
    chk("post_init_stall", stall_fetch, 0);
    mon_on = 1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    model_reset();
    #3 reset = 1;
    #1 check_reset();
    @(negedge clk);
    reset = 0;
    sweep(101);
    #1 reset = 1;
    #1 check_reset();
    restart();
    cycle(1, 32'h100, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 32'h900);
    cycle(1, 32'h200, 1, 0, 0, 0);
    cycle(1, 32'h300, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 32'h999);
    cycle(0, 0, 0, 1, 1, 32'h888);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 32'h400, 0, 0, 0, 0);
    cycle(1, 32'h500, 1, 1, 1, 32'h80);
    cycle(1, 32'h504, 1, 0, 0, 0);
    cycle(1, 32'h700, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 32'h40);
    for (int i = 0; i < 5; i++) cycle(1, 32'h1000 + 4 * i, i[0], 0, 0, 0);
    cycle(1, 32'h2000, 1, 1, mq[0].pred, 0);
    while (mq.size() > 0) cycle(0, 0, 0, 1, mq[0].pred, 0);
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 1), $urandom & 32'hFFFF_FFFC, $urandom_range(0, 1),
            ($urandom_range(0, 9) < 4) && (mq.size() > 0), $urandom_range(0, 1), $urandom);
    while (mq.size() > 0) cycle(0, 0, 0, 1, mq[0].pred, 0);
    cycle(1, 32'h600, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    #6;
    chk("scoreboard_drained", expq.size(), 0);
    chk("flush_before_reset", flush, 1);
    reset = 1;
    mon_on = 0;
    #1 check_reset();
    model_reset();
    restart();
    cycle(1, 32'hFFFF_FFFC, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("final_drained", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
